md_sequencer: RTL and testbench

Sequencer for the iterative multiply/divide datapath. It accepts multiply and divide requests from the processor and latches the operation mode. It then steps the MD iteration counter and issues per-step accumulator controls: radix-4 recoded add/subtract for multiply, non-restoring add/subtract for divide. It sits between processor op decode and the mult/div register/accumulator logic, and drives BUSY back to the processor.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_recode.sv | 43 ++++
 rtl/md_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_md_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
// Holds the sequencer state encoding, the accumulator operation codes
// driven on ACC_OP, and the default iteration counts for multiply and divide.
package md_pkg;

  // Sequencer phases; the registered outputs always describe the phase held
  // in the state register.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } md_state_e;

  // Accumulator controls; 2'b11 is never produced.
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_ADD  = 2'b01;
  localparam logic [1:0] ACC_SUB  = 2'b10;

  // Multiply retires two multiplier bits per step on a 26-bit operand,
  // divide produces one quotient bit per step.
  localparam int MPY_STEPS_DEF = 13;
  localparam int DIV_STEPS_DEF = 26;
  localparam int CNT_W_DEF     = 5;

endpackage

// File: rtl/md_recode.sv
// md_recode: radix-4 multiplier recoder for one multiply iteration.
// Purely combinational.
//   mplr   in  2  current low multiplier bits from the datapath
//   c_in   in  1  recode carry from the previous step
//   acc_op out 2  accumulator operation (none/add/subtract)
//   acc_x2 out 1  multiplicand applied doubled
//   c_out  out 1  recode carry for the next step
module md_recode
  import md_pkg::*;
(
  input  logic [1:0] mplr,
  input  logic       c_in,
  output logic [1:0] acc_op,
  output logic       acc_x2,
  output logic       c_out
);

  logic [2:0] digit_sum;

  // The digit value mplr + carry ranges 0..4. Values 3 and 4 are folded
  // into (-1, +4) and (0, +4): subtract/no-op now, carry one into the next
  // digit, which keeps every step to a single +-1x or +2x add.
  always_comb begin
    digit_sum = {1'b0, mplr} + {2'b00, c_in};
    acc_op    = ACC_NONE;
    acc_x2    = 1'b0;
    c_out     = 1'b0;
    case (digit_sum)
      3'd1: acc_op = ACC_ADD;
      3'd2: begin
        acc_op = ACC_ADD;
        acc_x2 = 1'b1;
      end
      3'd3: begin
        acc_op = ACC_SUB;
        c_out  = 1'b1;
      end
      3'd4: c_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: control sequencer for the iterative multiply/divide datapath.
// Latches the requested mode, steps the iteration counter and issues the
// per-step accumulator controls (radix-4 recoded for multiply, non-restoring
// for divide). Every output is registered and updates only on CLK edges with
// STEP_EN high.
//   CLK, RESETN         clock, asynchronous active-low reset
//   STEP_EN             one-cycle strobe per datapath bit-time
//   MPY_REQ, DIV_REQ    operation requests (levels, sampled in IDLE)
//   ABORT               cancel any operation in progress
//   MPLR, REM_NEG       multiplier low bits / partial remainder sign
//   BUSY, HOY, VOY      in progress / multiply mode / divide mode
//   LOAD_MD, SHIFT_MD   operand load / per-step shift
//   ACC_OP, ACC_X2      accumulator operation and doubling
//   QBIT                quotient bit shifted in during divide
//   STEP_CNT            iterations remaining
//   RESULT_VALID        one-step completion pulse
//   REQ_REJ             one-step pulse for a request seen while busy
module md_sequencer
  import md_pkg::*;
#(
  parameter int MPY_STEPS = MPY_STEPS_DEF,
  parameter int DIV_STEPS = DIV_STEPS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             STEP_EN,
  input  logic             MPY_REQ,
  input  logic             DIV_REQ,
  input  logic             ABORT,
  input  logic [1:0]       MPLR,
  input  logic             REM_NEG,
  output logic             BUSY,
  output logic             HOY,
  output logic             VOY,
  output logic             LOAD_MD,
  output logic             SHIFT_MD,
  output logic [1:0]       ACC_OP,
  output logic             ACC_X2,
  output logic             QBIT,
  output logic [CNT_W-1:0] STEP_CNT,
  output logic             RESULT_VALID,
  output logic             REQ_REJ
);

  md_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             hoy_q, hoy_d;
  logic             voy_q, voy_d;
  logic             load_md_q, load_md_d;
  logic             shift_md_q, shift_md_d;
  logic [1:0]       acc_op_q, acc_op_d;
  logic             acc_x2_q, acc_x2_d;
  logic             qbit_q, qbit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             result_valid_q, result_valid_d;
  logic             req_rej_q, req_rej_d;
  logic             carry_q, carry_d;

  logic [1:0]       rc_acc_op;
  logic             rc_acc_x2;
  logic             rc_carry;

  md_recode u_recode (
    .mplr   (MPLR),
    .c_in   (carry_q),
    .acc_op (rc_acc_op),
    .acc_x2 (rc_acc_x2),
    .c_out  (rc_carry)
  );

  // Next-state and next-output logic. The decision taken on a step edge
  // produces the outputs of the phase being entered, so an ITER step is
  // issued from both LOAD and ITER until the counter has reached zero.
  always_comb begin
    state_d        = state_q;
    busy_d         = 1'b0;
    hoy_d          = hoy_q;
    voy_d          = voy_q;
    load_md_d      = 1'b0;
    shift_md_d     = 1'b0;
    acc_op_d       = ACC_NONE;
    acc_x2_d       = 1'b0;
    qbit_d         = 1'b0;
    cnt_d          = cnt_q;
    result_valid_d = 1'b0;
    req_rej_d      = 1'b0;
    carry_d        = carry_q;

    unique case (state_q)
      IDLE: begin
        if (MPY_REQ) begin
          state_d   = LOAD;
          hoy_d     = 1'b1;
          cnt_d     = CNT_W'(MPY_STEPS);
          load_md_d = 1'b1;
          busy_d    = 1'b1;
          carry_d   = 1'b0;
        end else if (DIV_REQ) begin
          state_d   = LOAD;
          voy_d     = 1'b1;
          cnt_d     = CNT_W'(DIV_STEPS);
          load_md_d = 1'b1;
          busy_d    = 1'b1;
          carry_d   = 1'b0;
        end
      end
      LOAD, ITER: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          // Final correction: pending recode carry or remainder restore.
          state_d  = FINAL;
          carry_d  = 1'b0;
          if (hoy_q) acc_op_d = carry_q ? ACC_ADD : ACC_NONE;
          else       acc_op_d = REM_NEG ? ACC_ADD : ACC_NONE;
        end else begin
          state_d    = ITER;
          shift_md_d = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (hoy_q) begin
            acc_op_d = rc_acc_op;
            acc_x2_d = rc_acc_x2;
            carry_d  = rc_carry;
          end else begin
            acc_op_d = REM_NEG ? ACC_ADD : ACC_SUB;
            qbit_d   = ~REM_NEG;
          end
        end
      end
      FINAL: begin
        state_d        = DONE;
        result_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        hoy_d   = 1'b0;
        voy_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        hoy_d   = 1'b0;
        voy_d   = 1'b0;
        cnt_d   = '0;
        carry_d = 1'b0;
      end
    endcase

    // A request arriving while busy is flagged but never disturbs the run.
    if ((state_q == LOAD || state_q == ITER || state_q == FINAL) &&
        (MPY_REQ || DIV_REQ)) begin
      req_rej_d = 1'b1;
    end

    // Abort wins over everything once an operation has started.
    if (ABORT && state_q != IDLE) begin
      state_d        = IDLE;
      busy_d         = 1'b0;
      hoy_d          = 1'b0;
      voy_d          = 1'b0;
      load_md_d      = 1'b0;
      shift_md_d     = 1'b0;
      acc_op_d       = ACC_NONE;
      acc_x2_d       = 1'b0;
      qbit_d         = 1'b0;
      cnt_d          = '0;
      result_valid_d = 1'b0;
      req_rej_d      = 1'b0;
      carry_d        = 1'b0;
    end
  end

  // State and output registers; STEP_EN low freezes everything, including
  // the one-step pulses.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      hoy_q          <= 1'b0;
      voy_q          <= 1'b0;
      load_md_q      <= 1'b0;
      shift_md_q     <= 1'b0;
      acc_op_q       <= ACC_NONE;
      acc_x2_q       <= 1'b0;
      qbit_q         <= 1'b0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      req_rej_q      <= 1'b0;
      carry_q        <= 1'b0;
    end else if (STEP_EN) begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      hoy_q          <= hoy_d;
      voy_q          <= voy_d;
      load_md_q      <= load_md_d;
      shift_md_q     <= shift_md_d;
      acc_op_q       <= acc_op_d;
      acc_x2_q       <= acc_x2_d;
      qbit_q         <= qbit_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      req_rej_q      <= req_rej_d;
      carry_q        <= carry_d;
    end
  end

  assign BUSY         = busy_q;
  assign HOY          = hoy_q;
  assign VOY          = voy_q;
  assign LOAD_MD      = load_md_q;
  assign SHIFT_MD     = shift_md_q;
  assign ACC_OP       = acc_op_q;
  assign ACC_X2       = acc_x2_q;
  assign QBIT         = qbit_q;
  assign STEP_CNT     = cnt_q;
  assign RESULT_VALID = result_valid_q;
  assign REQ_REJ      = req_rej_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed, self-checking bench for md_sequencer.
// All outputs are compared together as one packed bundle
// {BUSY,HOY,VOY,LOAD_MD,SHIFT_MD,ACC_OP,ACC_X2,QBIT,STEP_CNT,RESULT_VALID,REQ_REJ}
// against hand-computed expectations after each step edge.
module tb_md_sequencer;

  logic       clk;
  logic       resetN;
  logic       stepEn;
  logic       mpyReq;
  logic       divReq;
  logic       abort;
  logic [1:0] mplr;
  logic       remNeg;
  logic       busy;
  logic       hoy;
  logic       voy;
  logic       loadMd;
  logic       shiftMd;
  logic [1:0] accOp;
  logic       accX2;
  logic       qbit;
  logic [4:0] stepCnt;
  logic       resultValid;
  logic       reqRej;

  int testsRun;
  int testsFailed;

  // Hand-derived recode sweep: per ITER step multiplier bits, expected
  // operation and doubling. Carry ends at 1 so FINAL must add.
  logic [1:0] recMplr [13] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3,
                               2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3};
  logic [1:0] recOp   [13] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                               2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10};
  logic       recX2   [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  md_sequencer dut (
    .CLK          (clk),
    .RESETN       (resetN),
    .STEP_EN      (stepEn),
    .MPY_REQ      (mpyReq),
    .DIV_REQ      (divReq),
    .ABORT        (abort),
    .MPLR         (mplr),
    .REM_NEG      (remNeg),
    .BUSY         (busy),
    .HOY          (hoy),
    .VOY          (voy),
    .LOAD_MD      (loadMd),
    .SHIFT_MD     (shiftMd),
    .ACC_OP       (accOp),
    .ACC_X2       (accX2),
    .QBIT         (qbit),
    .STEP_CNT     (stepCnt),
    .RESULT_VALID (resultValid),
    .REQ_REJ      (reqRej)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle.
  function automatic logic [31:0] outBundle();
    return {16'd0, busy, hoy, voy, loadMd, shiftMd, accOp, accX2, qbit,
            stepCnt, resultValid, reqRej};
  endfunction

  // Expected output bundle built from individual fields.
  function automatic logic [31:0] expv(input logic b, input logic h,
                                       input logic v, input logic ld,
                                       input logic sh, input logic [1:0] op,
                                       input logic x2, input logic q,
                                       input logic [4:0] cnt, input logic rv,
                                       input logic rj);
    return {16'd0, b, h, v, ld, sh, op, x2, q, cnt, rv, rj};
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present inputs away from the active edge and give one STEP_EN edge;
  // returns 1 time unit after that edge so outputs can be sampled.
  task automatic applyStimulus(input logic m, input logic d, input logic ab,
                               input logic [1:0] mp, input logic rn);
    @(negedge clk);
    mpyReq = m;
    divReq = d;
    abort  = ab;
    mplr   = mp;
    remNeg = rn;
    stepEn = 1'b1;
    @(posedge clk);
    #1;
    stepEn = 1'b0;
  endtask

  // Clock edges with STEP_EN low.
  task automatic idleClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetN = 1'b0;
    stepEn = 1'b0;
    mpyReq = 1'b0;
    divReq = 1'b0;
    abort  = 1'b0;
    mplr   = 2'b00;
    remNeg = 1'b0;

    #12;
    checkOutput("reset", outBundle(), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    idleClocks(2);
    checkOutput("idle no step", outBundle(), 32'd0);

    // Multiply, MPLR held at 01: every ITER step adds x1.
    $display("[TB] multiply with MPLR=01");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    checkOutput("mpy1 load", outBundle(),
                expv(1, 1, 0, 1, 0, 2'b00, 0, 0, 5'd13, 0, 0));
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
      checkOutput($sformatf("mpy1 iter%0d", k), outBundle(),
                  expv(1, 1, 0, 0, 1, 2'b01, 0, 0, 5'(13 - k), 0, 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    checkOutput("mpy1 final", outBundle(),
                expv(1, 1, 0, 0, 0, 2'b00, 0, 0, 5'd0, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    checkOutput("mpy1 done", outBundle(),
                expv(0, 1, 0, 0, 0, 2'b00, 0, 0, 5'd0, 1, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    checkOutput("mpy1 idle", outBundle(), 32'd0);

    // Recode sweep: subtract, none (v=4), add (v=1), ... ending with carry.
    $display("[TB] multiply recode sweep");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rec load", outBundle(),
                expv(1, 1, 0, 1, 0, 2'b00, 0, 0, 5'd13, 0, 0));
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, recMplr[i], 1'b0);
      checkOutput($sformatf("rec iter%0d", i + 1), outBundle(),
                  expv(1, 1, 0, 0, 1, recOp[i], recX2[i], 0, 5'(12 - i), 0, 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rec final carry add", outBundle(),
                expv(1, 1, 0, 0, 0, 2'b01, 0, 0, 5'd0, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rec done", outBundle(),
                expv(0, 1, 0, 0, 0, 2'b00, 0, 0, 5'd0, 1, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rec idle", outBundle(), 32'd0);

    // Divide with REM_NEG alternating 0,1.
    $display("[TB] divide alternating remainder sign");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("div load", outBundle(),
                expv(1, 0, 1, 1, 0, 2'b00, 0, 0, 5'd26, 0, 0));
    for (int i = 1; i <= 26; i++) begin
      if (i % 2 == 1) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput($sformatf("div iter%0d", i), outBundle(),
                    expv(1, 0, 1, 0, 1, 2'b10, 0, 1, 5'(26 - i), 0, 0));
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        checkOutput($sformatf("div iter%0d", i), outBundle(),
                    expv(1, 0, 1, 0, 1, 2'b01, 0, 0, 5'(26 - i), 0, 0));
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("div final restore", outBundle(),
                expv(1, 0, 1, 0, 0, 2'b01, 0, 0, 5'd0, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("div done", outBundle(),
                expv(0, 0, 1, 0, 0, 2'b00, 0, 0, 5'd0, 1, 0));
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("req in done ignored", outBundle(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("after done idle", outBundle(), 32'd0);

    // Both requests: multiply wins; held DIV_REQ is rejected each step.
    $display("[TB] simultaneous requests, reject and abort");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("both load", outBundle(),
                expv(1, 1, 0, 1, 0, 2'b00, 0, 0, 5'd13, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      checkOutput($sformatf("rej iter%0d", k), outBundle(),
                  expv(1, 1, 0, 0, 1, 2'b00, 0, 0, 5'(13 - k), 0, 1));
    end
    idleClocks(2);
    checkOutput("rej held in gap", outBundle(),
                expv(1, 1, 0, 0, 1, 2'b00, 0, 0, 5'd9, 0, 1));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rej drop", outBundle(),
                expv(1, 1, 0, 0, 1, 2'b00, 0, 0, 5'd8, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("cnt seven", outBundle(),
                expv(1, 1, 0, 0, 1, 2'b00, 0, 0, 5'd7, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    checkOutput("abort", outBundle(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("abort no valid", outBundle(), 32'd0);

    // Fresh divide after abort, with STEP_EN gaps between steps.
    $display("[TB] divide with step gaps and async reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("div2 load", outBundle(),
                expv(1, 0, 1, 1, 0, 2'b00, 0, 0, 5'd26, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      logic [31:0] e;
      if (k % 2 == 1) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        e = expv(1, 0, 1, 0, 1, 2'b01, 0, 0, 5'(26 - k), 0, 0);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        e = expv(1, 0, 1, 0, 1, 2'b10, 0, 1, 5'(26 - k), 0, 0);
      end
      checkOutput($sformatf("gap iter%0d", k), outBundle(), e);
      idleClocks(2);
      checkOutput($sformatf("gap hold%0d", k), outBundle(), e);
    end

    // Asynchronous reset between clock edges, STEP_EN low.
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async reset", outBundle(), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // ABORT in IDLE does not block a simultaneous request.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    checkOutput("abort in idle", outBundle(),
                expv(1, 1, 0, 1, 0, 2'b00, 0, 0, 5'd13, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    checkOutput("abort in load", outBundle(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
